// File: rtl/sync_fifo_pkg.sv
// Shared helpers and types for the parametrised synchronous FIFO.
package sync_fifo_pkg;

  localparam int DEF_D_WIDTH = 8;
  localparam int DEF_D_DEPTH = 16;

  // Index width of the storage array; pointers and count carry one extra wrap bit.
  function automatic int addr_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  typedef struct packed {
    logic isEmpty;
    logic isFull;
    logic isAlmostEmpty;
    logic isAlmostFull;
  } fifo_status_t;

endpackage

// File: rtl/sync_fifo_mem.sv
// Register array with one synchronous write port and one asynchronous read port.
module sync_fifo_mem #(
  parameter int D_WIDTH = 8,
  parameter int AW      = 4
) (
  input  logic               clk,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [D_WIDTH-1:0] wdata,
  input  logic [AW-1:0]      raddr,
  output logic [D_WIDTH-1:0] rdata
);

  logic [D_WIDTH-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_v2.sv
// Parametrised synchronous FIFO with occupancy flags and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads.
module sync_fifo_v2
  import sync_fifo_pkg::*;
#(
  parameter int D_WIDTH = DEF_D_WIDTH,
  parameter int D_DEPTH = DEF_D_DEPTH,
  parameter int AF_LVL  = D_DEPTH - 2,
  parameter int AE_LVL  = 2,
  localparam int AW     = addr_width(D_DEPTH)
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               w_en,
  input  logic [D_WIDTH-1:0] w_data,
  input  logic               r_en,
  input  logic               flush,
  input  logic               clr_err,
  output logic [D_WIDTH-1:0] r_data,
  output logic               r_valid,
  output logic               isEmpty,
  output logic               isFull,
  output logic               isAlmostEmpty,
  output logic               isAlmostFull,
  output logic [AW:0]        count,
  output logic               overflow,
  output logic               underflow
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(D_DEPTH);
  localparam logic [AW:0] AF_C    = (AW+1)'(AF_LVL);
  localparam logic [AW:0] AE_C    = (AW+1)'(AE_LVL);
  localparam logic [AW:0] ONE_C   = (AW+1)'(1);

  logic [AW:0]        w_ptr, r_ptr;
  logic [D_WIDTH-1:0] mem_rdata;
  fifo_status_t       st;
  logic               wr_acc, rd_acc;

  assign count            = w_ptr - r_ptr;
  assign st.isEmpty       = (w_ptr == r_ptr);
  assign st.isFull        = (w_ptr[AW-1:0] == r_ptr[AW-1:0]) && (w_ptr[AW] != r_ptr[AW]);
  assign st.isAlmostEmpty = (count <= AE_C);
  assign st.isAlmostFull  = (count >= AF_C);

  assign isEmpty       = st.isEmpty;
  assign isFull        = st.isFull;
  assign isAlmostEmpty = st.isAlmostEmpty;
  assign isAlmostFull  = st.isAlmostFull;

  // Flush swallows both requests, so neither can move a pointer or raise an error.
  assign wr_acc = w_en && !st.isFull  && !flush;
  assign rd_acc = r_en && !st.isEmpty && !flush;

  sync_fifo_mem #(
    .D_WIDTH (D_WIDTH),
    .AW      (AW)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc && n_rst),
    .waddr (w_ptr[AW-1:0]),
    .wdata (w_data),
    .raddr (r_ptr[AW-1:0]),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      w_ptr <= '0;
      r_ptr <= '0;
    end else if (flush) begin
      w_ptr <= '0;
      r_ptr <= '0;
    end else begin
      if (wr_acc) w_ptr <= w_ptr + ONE_C;
      if (rd_acc) r_ptr <= r_ptr + ONE_C;
    end
  end

  // A new error event wins over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (w_en && st.isFull  && !flush) || (overflow  && !clr_err);
      underflow <= (r_en && st.isEmpty && !flush) || (underflow && !clr_err);
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign r_data  = st.isEmpty ? '0 : mem_rdata;
  assign r_valid = !st.isEmpty;
`else
  logic [D_WIDTH-1:0] r_data_q;
  logic               r_valid_q;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_data_q  <= '0;
      r_valid_q <= 1'b0;
    end else if (flush) begin
      r_valid_q <= 1'b0;
    end else begin
      r_valid_q <= rd_acc;
      if (rd_acc) r_data_q <= mem_rdata;
    end
  end

  assign r_data  = r_data_q;
  assign r_valid = r_valid_q;
`endif

endmodule

// File: tb/tb_sync_fifo_v2.sv
// Randomised self-checking bench for sync_fifo_v2 against a queue-based model.
module tb_sync_fifo_v2;

  localparam int W  = 8;
  localparam int D  = 16;
  localparam int AF = D - 2;
  localparam int AE = 2;

  logic         clk = 1'b0;
  logic         n_rst, w_en, r_en, flush, clr_err;
  logic [W-1:0] w_data, r_data;
  logic         r_valid, isEmpty, isFull, isAlmostEmpty, isAlmostFull;
  logic [4:0]   count;
  logic         overflow, underflow;

  always #5 clk = ~clk;

  sync_fifo_v2 dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .w_en          (w_en),
    .w_data        (w_data),
    .r_en          (r_en),
    .flush         (flush),
    .clr_err       (clr_err),
    .r_data        (r_data),
    .r_valid       (r_valid),
    .isEmpty       (isEmpty),
    .isFull        (isFull),
    .isAlmostEmpty (isAlmostEmpty),
    .isAlmostFull  (isAlmostFull),
    .count         (count),
    .overflow      (overflow),
    .underflow     (underflow)
  );

  int n_chk  = 0;
  int n_pass = 0;

  logic [W-1:0] q [$];
  logic [W-1:0] m_rd  = '0;
  logic         m_rv  = 1'b0;
  logic         m_ovf = 1'b0;
  logic         m_udf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
  endtask

  // Reference behaviour: a plain queue plus a handful of scalars.
  task automatic model(input logic rst, input logic w, input logic [W-1:0] wd,
                       input logic r, input logic fl, input logic ce);
    int sz;
    sz = q.size();
    if (!rst) begin
      q.delete();
      m_rd = '0; m_rv = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
    end else if (fl) begin
      q.delete();
      m_rv  = 1'b0;
      m_ovf = m_ovf && !ce;
      m_udf = m_udf && !ce;
    end else begin
      m_ovf = (w && sz == D) || (m_ovf && !ce);
      m_udf = (r && sz == 0) || (m_udf && !ce);
      m_rv  = 1'b0;
      if (r && sz != 0) begin
        m_rd = q.pop_front();
        m_rv = 1'b1;
      end
      if (w && sz != D) q.push_back(wd);
    end
  endtask

  task automatic check_all();
    int sz;
    sz = q.size();
    chk("count",     32'(count),         32'(sz));
    chk("isEmpty",   32'(isEmpty),       32'(sz == 0));
    chk("isFull",    32'(isFull),        32'(sz == D));
    chk("isAlmEmp",  32'(isAlmostEmpty), 32'(sz <= AE));
    chk("isAlmFull", 32'(isAlmostFull),  32'(sz >= AF));
    chk("overflow",  32'(overflow),      32'(m_ovf));
    chk("underflow", 32'(underflow),     32'(m_udf));
`ifdef SYNC_FIFO_FWFT_EN
    chk("r_valid",   32'(r_valid),       32'(sz != 0));
    chk("r_data",    32'(r_data),        (sz != 0) ? 32'(q[0]) : 32'd0);
`else
    chk("r_valid",   32'(r_valid),       32'(m_rv));
    chk("r_data",    32'(r_data),        32'(m_rd));
`endif
  endtask

  task automatic step(input logic rst, input logic w, input logic [W-1:0] wd,
                      input logic r, input logic fl, input logic ce);
    n_rst = rst; w_en = w; w_data = wd; r_en = r; flush = fl; clr_err = ce;
    model(rst, w, wd, r, fl, ce);
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    logic [W-1:0] d;
    int pw, pr;
    n_rst = 1'b0; w_en = 1'b0; w_data = '0; r_en = 1'b0; flush = 1'b0; clr_err = 1'b0;
    #1;

    step(0, 0, 8'h00, 0, 0, 0);
    step(0, 1, 8'h11, 1, 0, 0);
    repeat (2) step(1, 0, 8'h00, 0, 0, 0);

    for (int i = 0; i < D; i++) step(1, 1, 8'(i), 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 1, 8'hE0 + 8'(i), 0, 0, 0);
    step(1, 0, 8'h00, 0, 0, 1);
    step(1, 1, 8'hEE, 1, 0, 0);
    step(1, 0, 8'h00, 0, 0, 1);
    for (int i = 0; i < D; i++) step(1, 0, 8'h00, 1, 0, 0);
    step(1, 0, 8'h00, 0, 0, 0);
    step(1, 0, 8'h00, 1, 0, 0);
    step(1, 1, 8'h77, 1, 0, 0);
    step(1, 0, 8'h00, 1, 0, 1);
    step(1, 0, 8'h00, 0, 0, 0);

    d = 8'h40;
    for (int i = 0; i < 4; i++) begin step(1, 1, d, 0, 0, 0); d++; end
    for (int i = 0; i < 40; i++) begin step(1, 1, d, 1, 0, 0); d++; end
    repeat (5) step(1, 0, 8'h00, 1, 0, 0);

    for (int i = 0; i < 9; i++) step(1, 1, 8'h90 + 8'(i), 0, 0, 0);
    step(1, 1, 8'hFF, 1, 1, 0);
    step(1, 1, 8'hA5, 0, 0, 0);
    step(1, 0, 8'h00, 1, 0, 0);
    step(1, 0, 8'h00, 0, 0, 0);

    step(1, 1, 8'h3C, 0, 0, 0);
    step(1, 0, 8'h00, 0, 0, 0);
    step(1, 0, 8'h00, 1, 0, 0);

    for (int blk = 0; blk < 48; blk++) begin
      pw = $urandom_range(100);
      pr = $urandom_range(100);
      for (int i = 0; i < 64; i++) begin
        step(($urandom_range(399) != 0),
             ($urandom_range(99) < pw),
             8'($urandom),
             ($urandom_range(99) < pr),
             ($urandom_range(79) == 0),
             ($urandom_range(29) == 0));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
